styler_pipe: RTL and testbench

Pipelined, parametrised character-cell styler for the text display path. Takes one glyph scanline per transfer with an attribute word and produces the styled bitmap row. It supports configurable glyph width and height, a valid/ready handshake with backpressure, and internal generation of the faint, blink and cursor phases from a frame pulse. It sits between the glyph-ROM fetch stage and the pixel serialiser, replacing the purely combinational styler for cells wider or taller than 16×16.

---
 rtl/styler_pipe_if.sv | 43 ++++
 rtl/styler_pipe.sv | 265 ++++++++++++++++++++++++++
 tb/tb_styler_pipe.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/styler_pipe_if.sv
// styler_pipe_if: transfer bundle between the glyph-ROM fetch stage, the
// styler pipeline and the pixel serialiser.
//
// Parameters:
//   W  - glyph width in pixels (width of the bitmap rows)
//   HB - scanline index width, log2 of the glyph height
//
// Signals:
//   inValid/inReady   - upstream handshake (one glyph scanline per transfer)
//   scanlineIn        - glyph row index of the transfer
//   bitmapIn          - glyph row, MSB is the leftmost pixel
//   attr              - 16-bit cell attribute word
//   outValid/outReady - downstream handshake
//   scanlineOut       - effective scanline after the y transform
//   bitmapOut         - styled row
//
// Modports:
//   master - the side that supplies glyph rows and consumes styled rows
//   slave  - the styler itself
interface styler_pipe_if #(
    parameter int W  = 16,
    parameter int HB = 4
);
    logic          inValid;
    logic          inReady;
    logic [HB-1:0] scanlineIn;
    logic [W-1:0]  bitmapIn;
    logic [15:0]   attr;
    logic          outValid;
    logic          outReady;
    logic [HB-1:0] scanlineOut;
    logic [W-1:0]  bitmapOut;

    modport master (
        output inValid, scanlineIn, bitmapIn, attr, outReady,
        input  inReady, outValid, scanlineOut, bitmapOut
    );

    modport slave (
        input  inValid, scanlineIn, bitmapIn, attr, outReady,
        output inReady, outValid, scanlineOut, bitmapOut
    );
endinterface

// File: rtl/styler_pipe.sv
// styler_pipe: three-stage pipelined character-cell styler.
//
// Stage 1 applies the y transform, detects the decoration lines, resolves
// the cursor and snapshots the faint/blink phases. Stage 2 applies italic,
// bold, x offset and x scale. Stage 3 applies solid fill, faint masking,
// hidden, blink and inverse, in that order. The whole pipe advances as one
// when the output register is empty or being drained.
//
// Parameters:
//   W          - glyph width, power of two, >= 8
//   H          - glyph height, power of two, >= 8
//   BLINK_DIV  - frame pulses per blink half-period, >= 1
//   CURSOR_DIV - frame pulses per cursor half-period, >= 1
//
// Ports:
//   clk        - single clock
//   rst        - synchronous active-high reset
//   frameStart - one-cycle pulse at the start of every frame
//   bus        - styler_pipe_if slave modport (in/out handshakes and data)
module styler_pipe #(
    parameter int W          = 16,
    parameter int H          = 16,
    parameter int BLINK_DIV  = 32,
    parameter int CURSOR_DIV = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frameStart,
    styler_pipe_if.slave bus
);
    localparam int HB  = $clog2(H);
    localparam int BCW = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;
    localparam int CCW = (CURSOR_DIV > 1) ? $clog2(CURSOR_DIV) : 1;

    localparam logic [HB-1:0] ROW_UNDER  = HB'(H - 3);
    localparam logic [HB-1:0] ROW_LAST   = HB'(H - 1);
    localparam logic [HB-1:0] ROW_STRIKE = HB'(H / 2 - 1);
    localparam logic [HB-1:0] ROW_HALF   = HB'(H / 2);

    typedef struct packed {
        logic cursorBlink;
        logic cursor;
        logic yoffset;
        logic yscale;
        logic xoffset;
        logic xscale;
        logic overline;
        logic strikethru;
        logic doubleUnderline;
        logic underline;
        logic blink;
        logic hidden;
        logic inverse;
        logic italic;
        logic faint;
        logic bold;
    } attr_t;

    typedef struct packed {
        logic [W-1:0]  bitmap;
        logic [HB-1:0] row;
        logic          solid;
        logic          bold;
        logic          faint;
        logic          italic;
        logic          inverse;
        logic          hidden;
        logic          blink;
        logic          xscale;
        logic          xoffset;
        logic          blinkPhase;
        logic          faintSel;
    } stage1_t;

    typedef struct packed {
        logic [W-1:0]  bitmap;
        logic [HB-1:0] row;
        logic          solid;
        logic          faint;
        logic          inverse;
        logic          hidden;
        logic          blink;
        logic          blinkPhase;
        logic          faintSel;
    } stage2_t;

    // Alternating faint mask: sel=1 gives ...0101 (even bits set), sel=0
    // gives ...1010.
    function automatic logic [W-1:0] faintMask(input logic sel);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) begin
            m[i] = (i % 2 == 0) ? sel : ~sel;
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Phase generator
    // ------------------------------------------------------------------
    logic           faintPhase;
    logic           blinkPhase;
    logic           cursorPhase;
    logic [BCW-1:0] blinkCnt;
    logic [CCW-1:0] cursorCnt;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            faintPhase  <= 1'b0;
            blinkPhase  <= 1'b0;
            cursorPhase <= 1'b0;
            blinkCnt    <= '0;
            cursorCnt   <= '0;
        end else if (frameStart) begin
            faintPhase <= ~faintPhase;
            if (blinkCnt == BCW'(BLINK_DIV - 1)) begin
                blinkCnt   <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                blinkCnt <= blinkCnt + BCW'(1);
            end
            if (cursorCnt == CCW'(CURSOR_DIV - 1)) begin
                cursorCnt   <= '0;
                cursorPhase <= ~cursorPhase;
            end else begin
                cursorCnt <= cursorCnt + CCW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic    adv;
    logic    s1Valid;
    logic    s2Valid;
    logic    outValidQ;
    logic [W-1:0]  bitmapOutQ;
    logic [HB-1:0] scanlineOutQ;
    stage1_t s1, s1Next;
    stage2_t s2, s2Next;
    logic [W-1:0] s3Bitmap;

    assign adv             = ~outValidQ | bus.outReady;
    assign bus.inReady     = adv;
    assign bus.outValid    = outValidQ;
    assign bus.bitmapOut   = bitmapOutQ;
    assign bus.scanlineOut = scanlineOutQ;

    // ------------------------------------------------------------------
    // Stage 1: y transform, line flags, cursor, phase snapshot
    // ------------------------------------------------------------------
    always_comb begin
        attr_t         a;
        logic [HB-1:0] s;
        logic          lineHit;
        logic          cursorOn;
        // NOTE: every combinational output gets a default before any
        // conditional update, so no path leaves a value held (no latch).
        a        = attr_t'(bus.attr);
        s        = bus.scanlineIn;
        if (a.yscale)  s = s >> 1;
        if (a.yoffset) s = s ^ ROW_HALF;

        lineHit  = (a.underline       && s == ROW_UNDER)
                 | (a.doubleUnderline && (s == ROW_UNDER || s == ROW_LAST))
                 | (a.strikethru      && s == ROW_STRIKE)
                 | (a.overline        && s == '0);
        cursorOn = a.cursor && (cursorPhase || !a.cursorBlink);

        s1Next            = '0;
        s1Next.bitmap     = bus.bitmapIn;
        s1Next.row        = s;
        s1Next.solid      = lineHit;
        s1Next.bold       = a.bold;
        s1Next.faint      = a.faint;
        s1Next.italic     = a.italic;
        s1Next.inverse    = a.inverse ^ cursorOn;
        s1Next.hidden     = a.hidden;
        s1Next.blink      = a.blink;
        s1Next.xscale     = a.xscale;
        s1Next.xoffset    = a.xoffset;
        s1Next.blinkPhase = blinkPhase;
        s1Next.faintSel   = faintPhase ^ s[0];
    end

    // ------------------------------------------------------------------
    // Stage 2: italic, bold, x offset, x scale
    // ------------------------------------------------------------------
    always_comb begin
        logic [W-1:0] b;
        logic [W-1:0] x;
        logic [1:0]   q;
        b = s1.bitmap;
        x = '0;
        q = s1.row[HB-1 -: 2];
        if (s1.italic) begin
            // Top quarter leans furthest right, bottom quarter one step left.
            case (q)
                2'd0:    b = b >> 2;
                2'd1:    b = b >> 1;
                2'd2:    b = b;
                default: b = b << 1;
            endcase
        end
        if (s1.bold)    b = b | (b >> 1);
        if (s1.xoffset) b = {b[W/2-1:0], b[W-1:W/2]};
        if (s1.xscale) begin
            for (int i = 0; i < W / 2; i++) begin
                x[2*i]   = b[W/2 + i];
                x[2*i+1] = b[W/2 + i];
            end
            b = x;
        end

        s2Next            = '0;
        s2Next.bitmap     = b;
        s2Next.row        = s1.row;
        s2Next.solid      = s1.solid;
        s2Next.faint      = s1.faint;
        s2Next.inverse    = s1.inverse;
        s2Next.hidden     = s1.hidden;
        s2Next.blink      = s1.blink;
        s2Next.blinkPhase = s1.blinkPhase;
        s2Next.faintSel   = s1.faintSel;
    end

    // ------------------------------------------------------------------
    // Stage 3: solid, faint, hidden, blink, inverse
    // ------------------------------------------------------------------
    always_comb begin
        s3Bitmap = s2.solid ? '1 : s2.bitmap;
        if (s2.faint)                  s3Bitmap = s3Bitmap & faintMask(s2.faintSel);
        if (s2.hidden)                 s3Bitmap = '0;
        if (s2.blink && s2.blinkPhase) s3Bitmap = '0;
        if (s2.inverse)                s3Bitmap = ~s3Bitmap;
    end

    // Valid bits and the visible outputs carry reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid      <= 1'b0;
            s2Valid      <= 1'b0;
            outValidQ    <= 1'b0;
            bitmapOutQ   <= '0;
            scanlineOutQ <= '0;
        end else if (adv) begin
            s1Valid      <= bus.inValid;
            s2Valid      <= s1Valid;
            outValidQ    <= s2Valid;
            bitmapOutQ   <= s3Bitmap;
            scanlineOutQ <= s2.row;
        end
    end

    // NOTE: internal stage payloads have no reset; they are only ever
    // consumed when their valid bit is set, which is reset above.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1 <= s1Next;
            s2 <= s2Next;
        end
    end
endmodule

// File: tb/tb_styler_pipe.sv
// tb_styler_pipe: directed, table-driven bench for styler_pipe with
// W=H=16, BLINK_DIV=2, CURSOR_DIV=3.
module tb_styler_pipe;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int HB = 4;

    logic clk = 1'b0;
    logic rst;
    logic frameStart;

    always #5 clk = ~clk;

    styler_pipe_if #(.W(W), .HB(HB)) bus ();

    styler_pipe #(
        .W(W), .H(H), .BLINK_DIV(2), .CURSOR_DIV(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frameStart (frameStart),
        .bus        (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  scan;
        logic [15:0] bmp;
        logic [15:0] at;
        logic [15:0] expB;
        logic [3:0]  expS;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input string n, input logic [3:0] s, input logic [15:0] b,
                                input logic [15:0] a, input logic [15:0] eb, input logic [3:0] es);
        vec_t v;
        v.name = n; v.scan = s; v.bmp = b; v.at = a; v.expB = eb; v.expS = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic pulseFrame();
        @(negedge clk);
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
    endtask

    // Send one word (optionally with a frame pulse in the same cycle) and
    // compare the resulting output once it appears.
    task automatic runVec(input string name, input logic [3:0] scan, input logic [15:0] bmp,
                          input logic [15:0] at, input logic fs,
                          input logic [15:0] expB, input logic [3:0] expS);
        int waited;
        @(negedge clk);
        bus.inValid    = 1'b1;
        bus.scanlineIn = scan;
        bus.bitmapIn   = bmp;
        bus.attr       = at;
        frameStart     = fs;
        @(negedge clk);
        bus.inValid = 1'b0;
        frameStart  = 1'b0;
        waited = 0;
        while (!bus.outValid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check({name, " outValid"}, bus.outValid, 1);
        if (bus.outValid) begin
            check({name, " bitmap"}, bus.bitmapOut, expB);
            check({name, " scanline"}, bus.scanlineOut, expS);
        end
    endtask

    initial begin
        int sent, got, stallLeft;
        logic stalled, seen;
        logic [15:0] held;

        rst = 1'b1; frameStart = 1'b0;
        bus.inValid = 1'b0; bus.scanlineIn = '0; bus.bitmapIn = '0;
        bus.attr = '0; bus.outReady = 1'b1;
        repeat (3) @(negedge clk);
        frameStart = 1'b1;              // must be ignored while in reset
        @(negedge clk);
        rst = 1'b0; frameStart = 1'b0;

        check("reset outValid", bus.outValid, 0);
        check("reset bitmapOut", bus.bitmapOut, 0);
        check("reset scanlineOut", bus.scanlineOut, 0);
        check("reset inReady", bus.inReady, 1);

        // Latency: outValid appears exactly three cycles after acceptance.
        @(negedge clk);
        bus.inValid = 1'b1; bus.scanlineIn = 4'd5; bus.bitmapIn = 16'h1234; bus.attr = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.inValid = 1'b0;
            if (c < 3) check($sformatf("latency c%0d outValid", c), bus.outValid, 0);
        end
        check("latency outValid", bus.outValid, 1);
        check("latency bitmap", bus.bitmapOut, 16'h1234);
        check("latency scanline", bus.scanlineOut, 5);

        // Phases are all zero here (no frame pulses outside reset yet).
        vecs.push_back(mk("plain",          4'd5,  16'h1234, 16'h0000, 16'h1234, 4'd5));
        vecs.push_back(mk("ul_yscale",      4'd13, 16'h00F0, 16'h1040, 16'h00F0, 4'd6));
        vecs.push_back(mk("ul_yoff_yscale", 4'd10, 16'h0000, 16'h3040, 16'hFFFF, 4'd13));
        vecs.push_back(mk("underline",      4'd13, 16'h0000, 16'h0040, 16'hFFFF, 4'd13));
        vecs.push_back(mk("italic_q0",      4'd0,  16'h8000, 16'h0004, 16'h2000, 4'd0));
        vecs.push_back(mk("italic_q1",      4'd4,  16'h8001, 16'h0004, 16'h4000, 4'd4));
        vecs.push_back(mk("italic_q2",      4'd8,  16'h8001, 16'h0004, 16'h8001, 4'd8));
        vecs.push_back(mk("italic_q3",      4'd12, 16'h8001, 16'h0004, 16'h0002, 4'd12));
        vecs.push_back(mk("bold_faint",     4'd0,  16'h0F00, 16'h0003, 16'h0A80, 4'd0));
        vecs.push_back(mk("faint_odd_row",  4'd1,  16'hFFFF, 16'h0002, 16'h5555, 4'd1));
        vecs.push_back(mk("faint_inverse",  4'd0,  16'hFFFF, 16'h000A, 16'h5555, 4'd0));
        vecs.push_back(mk("hidden",         4'd2,  16'hFFFF, 16'h0010, 16'h0000, 4'd2));
        vecs.push_back(mk("inverse",        4'd2,  16'h00FF, 16'h0008, 16'hFF00, 4'd2));
        vecs.push_back(mk("hidden_inverse", 4'd2,  16'h1234, 16'h0018, 16'hFFFF, 4'd2));
        vecs.push_back(mk("xoffset",        4'd3,  16'h1234, 16'h0800, 16'h3412, 4'd3));
        vecs.push_back(mk("xscale",         4'd3,  16'hA500, 16'h0400, 16'hCC33, 4'd3));
        vecs.push_back(mk("xoff_xscale",    4'd3,  16'h00A5, 16'h0C00, 16'hCC33, 4'd3));
        vecs.push_back(mk("dbl_ul_last",    4'd15, 16'h0000, 16'h0080, 16'hFFFF, 4'd15));
        vecs.push_back(mk("dbl_ul_miss",    4'd14, 16'h0001, 16'h0080, 16'h0001, 4'd14));
        vecs.push_back(mk("strikethru",     4'd7,  16'h0000, 16'h0100, 16'hFFFF, 4'd7));
        vecs.push_back(mk("overline",       4'd0,  16'h0000, 16'h0200, 16'hFFFF, 4'd0));
        vecs.push_back(mk("overline_miss",  4'd1,  16'h0101, 16'h0200, 16'h0101, 4'd1));
        vecs.push_back(mk("cursor_steady",  4'd6,  16'h0000, 16'h4000, 16'hFFFF, 4'd6));
        vecs.push_back(mk("cursor_blink_off", 4'd6, 16'h1234, 16'hC000, 16'h1234, 4'd6));
        vecs.push_back(mk("blink_phase0",   4'd2,  16'h1234, 16'h0020, 16'h1234, 4'd2));
        vecs.push_back(mk("solid_inverse",  4'd13, 16'h0F0F, 16'h0048, 16'h0000, 4'd13));
        vecs.push_back(mk("italic_bold",    4'd0,  16'h8000, 16'h0005, 16'h3000, 4'd0));
        vecs.push_back(mk("yoffset",        4'd3,  16'h0001, 16'h2000, 16'h0001, 4'd11));

        foreach (vecs[i]) begin
            runVec(vecs[i].name, vecs[i].scan, vecs[i].bmp, vecs[i].at, 1'b0,
                   vecs[i].expB, vecs[i].expS);
        end

        // Blink (div 2) blanks after pulses 2,3; cursor (div 3) active from pulse 3.
        for (int p = 1; p <= 4; p++) begin
            pulseFrame();
            runVec($sformatf("blink p%0d", p), 4'd2, 16'h1234, 16'h0020, 1'b0,
                   (p == 2 || p == 3) ? 16'h0000 : 16'h1234, 4'd2);
            runVec($sformatf("cursor_blink p%0d", p), 4'd6, 16'h0F0F, 16'hC000, 1'b0,
                   (p >= 3) ? 16'hF0F0 : 16'h0F0F, 4'd6);
            if (p == 1) runVec("faint phase1", 4'd0, 16'hFFFF, 16'h0002, 1'b0, 16'h5555, 4'd0);
        end

        // faintPhase is 0 after four pulses; a pulse in the accept cycle
        // must not affect that word, only the next one.
        runVec("faint same-cycle frame", 4'd0, 16'hFFFF, 16'h0002, 1'b1, 16'hAAAA, 4'd0);
        runVec("faint after frame", 4'd0, 16'hFFFF, 16'h0002, 1'b0, 16'h5555, 4'd0);

        // Backpressure: five words, outReady low for four cycles after the first.
        sent = 0; got = 0; stallLeft = 0; stalled = 1'b0; held = '0;
        bus.outReady = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            @(negedge clk);
            if (bus.outValid && bus.outReady) begin
                check($sformatf("bp word%0d bitmap", got), bus.bitmapOut, 16'hB000 + got);
                check($sformatf("bp word%0d scanline", got), bus.scanlineOut, 4'(got + 2));
                got++;
                if (got == 1) stallLeft = 4;
            end else if (bus.outValid && !bus.outReady) begin
                check("bp stall inReady", bus.inReady, 0);
                if (!stalled) begin
                    held = bus.bitmapOut;
                    stalled = 1'b1;
                end else begin
                    check("bp stall held", bus.bitmapOut, held);
                end
            end
            if (bus.inValid && bus.inReady) sent++;
            if (stallLeft > 0) begin
                bus.outReady = 1'b0;
                stallLeft--;
            end else begin
                bus.outReady = 1'b1;
            end
            bus.inValid    = (sent < 5);
            bus.bitmapIn   = 16'(16'hB000 + sent);
            bus.scanlineIn = 4'(sent + 2);
            bus.attr       = '0;
        end
        bus.inValid = 1'b0;
        bus.outReady = 1'b1;
        check("bp words received", got, 5);
        check("bp stall observed", stalled, 1);
        repeat (3) @(negedge clk);
        check("bp no duplicate", bus.outValid, 0);

        // Reset mid-stream with nonzero phases (7 pulses so far after this).
        pulseFrame();
        pulseFrame();
        for (int i = 0; i < 3; i++) begin
            bus.inValid = 1'b1; bus.bitmapIn = 16'(16'hC000 + i);
            bus.scanlineIn = 4'(i); bus.attr = '0;
            @(negedge clk);
        end
        check("pre-reset outValid", bus.outValid, 1);
        rst = 1'b1; frameStart = 1'b1; bus.inValid = 1'b0;
        @(negedge clk);
        rst = 1'b0; frameStart = 1'b0;
        check("midrst outValid", bus.outValid, 0);
        check("midrst bitmapOut", bus.bitmapOut, 0);
        check("midrst scanlineOut", bus.scanlineOut, 0);
        check("midrst inReady", bus.inReady, 1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.outValid) seen = 1'b1;
        end
        check("midrst no stale output", seen, 0);
        runVec("midrst faint phase0", 4'd0, 16'hFFFF, 16'h0002, 1'b0, 16'hAAAA, 4'd0);
        runVec("midrst blink phase0", 4'd2, 16'h1234, 16'h0020, 1'b0, 16'h1234, 4'd2);
        pulseFrame();
        runVec("midrst blink cnt0", 4'd2, 16'h1234, 16'h0020, 1'b0, 16'h1234, 4'd2);
        pulseFrame();
        runVec("midrst blink wrap", 4'd2, 16'h1234, 16'h0020, 1'b0, 16'h0000, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
